// File: rtl/program_loader_if.sv
// Byte-stream, program-memory write and status signals between the host side
// and the boot loader; slave is the loader, master is the host/memory side.
interface program_loader_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 18
);
    logic                 i_start;
    logic [0:7]           i_byte;
    logic                 i_valid;
    logic                 o_ready;
    logic                 o_wrEn;
    logic [0:ADDR_W-1]    o_wrAddr;
    logic [0:INSTR_W-1]   o_wrData;
    logic                 o_cpuHold;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;

    modport slave (
        input  i_start, i_byte, i_valid,
        output o_ready, o_wrEn, o_wrAddr, o_wrData,
        output o_cpuHold, o_busy, o_done, o_error
    );

    modport master (
        output i_start, i_byte, i_valid,
        input  o_ready, o_wrEn, o_wrAddr, o_wrData,
        input  o_cpuHold, o_busy, o_done, o_error
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles 18-bit instructions from a byte stream, writes them to
// program memory and releases the CPU only after the image checksum matches.
module program_loader #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 18
) (
    input  logic            i_clock,
    input  logic            i_reset,
    program_loader_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LEN_HI = 4'd1,
        S_LEN_LO = 4'd2,
        S_B0     = 4'd3,
        S_B1     = 4'd4,
        S_B2     = 4'd5,
        S_CSUM   = 4'd6,
        S_DONE   = 4'd7,
        S_ERROR  = 4'd8
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_ready, r_busy, r_done, r_error, r_cpuHold;
    logic                w_ready, w_busy, w_done, w_error, w_cpuHold;
    logic                w_accept;
    logic                w_lastWord;
    logic [15:0]         r_len;
    logic [15:0]         r_wordCnt;
    logic [7:0]          r_acc;
    logic [1:0]          r_b0Lo;
    logic [7:0]          r_b1;
    logic                r_wrEn;
    logic [ADDR_W-1:0]   r_wrAddr;
    logic [INSTR_W-1:0]  r_wrData;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign w_accept   = bus.i_valid & r_ready;
    assign w_lastWord = (r_wordCnt == (r_len - 16'd1));

    // State register plus status flags decoded one state ahead, so they are registered
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_cpuHold <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_ready   <= w_ready;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_error   <= w_error;
            r_cpuHold <= w_cpuHold;
        end
    end

    // Next-state selection
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.i_start) w_nextState = S_LEN_HI;
                else             w_nextState = r_state;
            end
            S_LEN_HI: begin
                if (w_accept) w_nextState = S_LEN_LO;
                else          w_nextState = r_state;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if ({r_len[15:8], bus.i_byte} == 16'd0) w_nextState = S_CSUM;
                    else                                    w_nextState = S_B0;
                end else begin
                    w_nextState = r_state;
                end
            end
            S_B0: begin
                if (w_accept) begin
                    if (bus.i_byte[0:5] != 6'd0) w_nextState = S_ERROR;
                    else                         w_nextState = S_B1;
                end else begin
                    w_nextState = r_state;
                end
            end
            S_B1: begin
                if (w_accept) w_nextState = S_B2;
                else          w_nextState = r_state;
            end
            S_B2: begin
                if (w_accept) begin
                    if (w_lastWord) w_nextState = S_CSUM;
                    else            w_nextState = S_B0;
                end else begin
                    w_nextState = r_state;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (bus.i_byte == r_acc) w_nextState = S_DONE;
                    else                     w_nextState = S_ERROR;
                end else begin
                    w_nextState = r_state;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Status flags for the state being entered
    always_comb begin
        w_ready   = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_error   = 1'b0;
        w_cpuHold = 1'b1;
        case (w_nextState)
            S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CSUM: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            S_DONE: begin
                w_done    = 1'b1;
                w_cpuHold = 1'b0;
            end
            S_ERROR: w_error = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Length latch, checksum, word assembly and the one-cycle memory write
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_len     <= 16'd0;
            r_wordCnt <= 16'd0;
            r_acc     <= 8'd0;
            r_b0Lo    <= 2'd0;
            r_b1      <= 8'd0;
            r_wrEn    <= 1'b0;
            r_wrAddr  <= {ADDR_W{1'b0}};
            r_wrData  <= {INSTR_W{1'b0}};
        end else begin
            r_wrEn <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.i_start) begin
                        r_acc     <= 8'd0;
                        r_wordCnt <= 16'd0;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= bus.i_byte;
                        r_acc       <= csum_add(r_acc, bus.i_byte);
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= bus.i_byte;
                        r_acc      <= csum_add(r_acc, bus.i_byte);
                    end
                end
                S_B0: begin
                    if (w_accept) begin
                        r_b0Lo <= bus.i_byte[6:7];
                        r_acc  <= csum_add(r_acc, bus.i_byte);
                    end
                end
                S_B1: begin
                    if (w_accept) begin
                        r_b1  <= bus.i_byte;
                        r_acc <= csum_add(r_acc, bus.i_byte);
                    end
                end
                S_B2: begin
                    if (w_accept) begin
                        r_wrEn    <= 1'b1;
                        r_wrAddr  <= ADDR_W'(r_wordCnt);
                        r_wrData  <= {r_b0Lo, r_b1, bus.i_byte};
                        r_wordCnt <= r_wordCnt + 16'd1;
                        r_acc     <= csum_add(r_acc, bus.i_byte);
                    end
                end
                default: r_wrEn <= 1'b0;
            endcase
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_busy    = r_busy;
    assign bus.o_done    = r_done;
    assign bus.o_error   = r_error;
    assign bus.o_cpuHold = r_cpuHold;
    assign bus.o_wrEn    = r_wrEn;
    assign bus.o_wrAddr  = r_wrAddr;
    assign bus.o_wrData  = r_wrData;
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the CPU. Receives a byte stream over a valid/ready handshake and assembles 18-bit instruction words from it.
- Writes those words into the program-memory write port and keeps the CPU held until a complete, checksum-verified image has been loaded.
- Sits between the host byte link (UART receiver) and the program memory/ROM write side. `o_cpuHold` gates the CPU clock enable.

Parameters:
- ADDR_W, 16, program address width (matches the instruction-pointer width).
- INSTR_W, 18, instruction width. Fixed at 3 bytes per word: 2 bits from byte0, 8 from byte1, 8 from byte2.

Ports:
- i_clock  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle request to begin a load.
- i_byte  in  [0:7]  stream byte; bit 0 is the MSB.
- i_valid  in  1  i_byte is valid.
- o_ready  out  1  loader accepts a byte this cycle.
- o_wrEn  out  1  program-memory write strobe, one cycle per word.
- o_wrAddr  out  [0:ADDR_W-1]  write address.
- o_wrData  out  [0:INSTR_W-1]  instruction word.
- o_cpuHold  out  1  holds the CPU in reset/stall while 1.
- o_busy  out  1  a load is in progress.
- o_done  out  1  image loaded and verified.
- o_error  out  1  load failed.

Behaviour:
- Reset (async, i_reset=1):
  - state=IDLE; o_cpuHold=1.
  - o_ready, o_wrEn, o_busy, o_done and o_error are all 0.
  - o_wrAddr=0, o_wrData=0; word counter=0; checksum accumulator=0.
- Byte acceptance:
  - A byte is accepted on a rising edge where i_valid=1 and o_ready=1.
  - o_ready=1 in states LEN_HI, LEN_LO, B0, B1, B2 and CSUM; 0 elsewhere.
  - i_valid gaps of any length are tolerated; the state holds.
- Stream format: LEN_HI, LEN_LO (word count N, big-endian, 0..65535), then N × {B0, B1, B2}, then CSUM.
- States and transitions:
  - IDLE: on i_start go to LEN_HI, set o_cpuHold=1, clear the accumulator and the address.
  - LEN_HI → LEN_LO: on accept, latch N[15:8].
  - LEN_LO: on accept, latch N[7:0]. If N=0 go to CSUM, else go to B0.
  - B0 → B1: on accept. If i_byte[0:5]≠0, go to ERROR instead and issue no write.
  - B1 → B2: on accept.
  - B2: on accept, go to B0 if this is not the last word, else go to CSUM.
  - CSUM: on accept, if i_byte equals the accumulator go to DONE, else go to ERROR.
  - DONE: o_done=1, o_cpuHold=0.
  - ERROR: o_error=1, o_cpuHold stays 1.
  - DONE/ERROR: i_start restarts the load (go to LEN_HI, clear flags, o_cpuHold=1).
- o_busy=1 in LEN_HI..CSUM. i_start is ignored while o_busy=1.
- Checksum: the accumulator is an 8-bit sum mod 256 of every accepted byte from LEN_HI through the last B2. The CSUM byte itself is excluded.
- Write timing:
  - The cycle after B2 is accepted, o_wrEn=1 for exactly one cycle.
  - o_wrAddr = word index (0-based).
  - o_wrData = {B0[6:7], B1[0:7], B2[0:7]}.
  - The address increments after the write. It never wraps, since the maximum index is N−1 ≤ 0xFFFE.
  - o_wrData/o_wrAddr hold their values between writes.
  - The B2 of the last word and the CSUM byte may arrive on back-to-back cycles; the write still occurs.
- Reset mid-load: all state is cleared immediately, o_cpuHold=1, and a partial word is not written. Already-written memory contents are not scrubbed.
- An error (pad bits or checksum) never releases o_cpuHold.

Test Plan:
- Reset then idle → o_cpuHold=1, o_ready=0, and o_busy/o_done/o_error/o_wrEn all 0. Asserting i_reset mid-cycle clears state asynchronously.
- Good load: start, then bytes 00 02 01 23 45 02 AB CD E5 at full rate.
  - Expect writes addr0=0x12345 and addr1=0x2ABCD, each a 1-cycle o_wrEn.
  - Then o_done=1, o_cpuHold=0.
- Same stream with checksum 0xE4 → both writes occur, o_error=1, o_cpuHold=1. A later i_start restarts the load and clears o_error.
- Empty image: bytes 00 00 00 → no o_wrEn, o_done=1.
- Pad error: 00 01 then 04 … → ERROR right after B0, with no write. Also randomize i_valid gaps on the good stream → identical writes and result.
- i_reset asserted after B1 of word 1 → immediate IDLE, no write for word 1, o_cpuHold=1. A fresh load then succeeds.
